// File: rtl/wb4_arbiter_pkg.sv
// wb4_arbiter_pkg: shared types and helpers for the Wishbone B4 two-master arbiter.
//   arb_state_e : arbiter FSM encoding (IDLE=0, GNT0=1, GNT1=2)
//   clog2       : ceil(log2(value)), used to size counters at elaboration
package wb4_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned n;
        v = (value > 0) ? value - 1 : 0;
        n = 0;
        while (v > 0) begin
            n = n + 1;
            v = v >> 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/wb4_arbiter_if.sv
// wb4_arbiter_if: one Wishbone B4 pipelined link.
//   cyc, stb, we, addr, wdata, sel : request, driven by the initiator
//   stall, ack, rdata              : response, driven by the target
//   modport master : initiator view; modport slave : target view
interface wb4_arbiter_if #(
    parameter int unsigned ARCHBITSZ = 32
);
    localparam int unsigned SELW = ARCHBITSZ / 8;

    logic                 cyc;
    logic                 stb;
    logic                 we;
    logic [ARCHBITSZ-1:0] addr;
    logic [ARCHBITSZ-1:0] wdata;
    logic [SELW-1:0]      sel;
    logic                 stall;
    logic                 ack;
    logic [ARCHBITSZ-1:0] rdata;

    modport master (output cyc, stb, we, addr, wdata, sel, input stall, ack, rdata);
    modport slave  (input cyc, stb, we, addr, wdata, sel, output stall, ack, rdata);
endinterface

// File: rtl/wb4_pending_cntr.sv
// wb4_pending_cntr: count of requests accepted by the slave but not yet acked.
//   clk, rst_n  : clock, synchronous active-low reset
//   inc, dec    : request accepted / ack received (both together: unchanged)
//   clr         : force the count to zero
//   full_c      : count == MAXPENDING
//   nz_c        : count != 0
//   next_zero_c : count after this edge will be zero
module wb4_pending_cntr
    import wb4_arbiter_pkg::*;
#(
    parameter int unsigned MAXPENDING = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec,
    input  logic clr,
    output logic full_c,
    output logic nz_c,
    output logic next_zero_c
);
    localparam int unsigned CW = clog2(MAXPENDING + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // An ack with nothing outstanding is a slave error and is dropped, never wrapping.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && !dec) begin
            count_d = count_q + CW'(1);
        end else if (dec && !inc && (count_q != '0)) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign full_c      = (count_q == CW'(MAXPENDING));
    assign nz_c        = (count_q != '0);
    assign next_zero_c = (count_d == '0);

endmodule

// File: rtl/wb4_arbiter.sv
// wb4_arbiter: two-master to one-slave Wishbone B4 pipelined arbiter.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   m0, m1        : master links (arbiter is their target)
//   s             : slave link (arbiter is its initiator)
// Round-robin grant held for the whole master cycle and until every accepted
// request has been acked; at most MAXPENDING requests in flight.
// Optional watchdog: define WB4_ARBITER_TIMEOUT_EN to abort after TIMEOUT
// ack-less cycles with requests outstanding.
module wb4_arbiter
    import wb4_arbiter_pkg::*;
#(
    parameter int unsigned ARCHBITSZ  = 32,
    parameter int unsigned MAXPENDING = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input logic           clk_i,
    input logic           rst_ni,
    wb4_arbiter_if.slave  m0,
    wb4_arbiter_if.slave  m1,
    wb4_arbiter_if.master s
);
    if (MAXPENDING < 1 || MAXPENDING > 15 || TIMEOUT < 1 ||
        (ARCHBITSZ != 16 && ARCHBITSZ != 32 && ARCHBITSZ != 64 && ARCHBITSZ != 128))
    begin : g_param_check
        $error("wb4_arbiter: unsupported parameter value");
    end

    arb_state_e state_q;
    arb_state_e state_d;
    logic       last_q;
    logic       last_d;
    logic       gnt0;
    logic       gnt1;
    logic       gnt_cyc;
    logic       gnt_stb;
    logic       full_c;
    logic       pend_nz_c;
    logic       next_zero_c;
    logic       accept;
    logic       ack_ok;
    logic       timeout_c;

    assign gnt0    = (state_q == GNT0);
    assign gnt1    = (state_q == GNT1);
    assign gnt_cyc = (gnt0 & m0.cyc) | (gnt1 & m1.cyc);
    assign gnt_stb = (gnt0 & m0.cyc & m0.stb) | (gnt1 & m1.cyc & m1.stb);

    // Slave request path, muxed from the granted master.
    assign s.cyc   = gnt_cyc | pend_nz_c;
    assign s.stb   = gnt_stb & ~full_c;
    assign s.we    = gnt1 ? m1.we    : m0.we;
    assign s.addr  = gnt1 ? m1.addr  : m0.addr;
    assign s.wdata = gnt1 ? m1.wdata : m0.wdata;
    assign s.sel   = gnt1 ? m1.sel   : m0.sel;

    assign accept  = s.stb & ~s.stall;
    // Acks with nothing outstanding (e.g. stragglers after reset) are not forwarded.
    assign ack_ok  = s.ack & pend_nz_c;

    // Response path; acks after the owner drops cyc are absorbed.
    assign m0.stall = gnt0 ? (s.stall | full_c) : 1'b1;
    assign m1.stall = gnt1 ? (s.stall | full_c) : 1'b1;
    assign m0.ack   = gnt0 & m0.cyc & (ack_ok | timeout_c);
    assign m1.ack   = gnt1 & m1.cyc & (ack_ok | timeout_c);
    assign m0.rdata = timeout_c ? '0 : s.rdata;
    assign m1.rdata = timeout_c ? '0 : s.rdata;

    wb4_pending_cntr #(
        .MAXPENDING (MAXPENDING)
    ) u_pending (
        .clk         (clk_i),
        .rst_n       (rst_ni),
        .inc         (accept),
        .dec         (s.ack),
        .clr         (timeout_c),
        .full_c      (full_c),
        .nz_c        (pend_nz_c),
        .next_zero_c (next_zero_c)
    );

`ifdef WB4_ARBITER_TIMEOUT_EN
    localparam int unsigned WDW = clog2(TIMEOUT + 1);
    logic [WDW-1:0] wd_q;

    // Counts consecutive ack-less cycles while requests are outstanding.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || s.ack || timeout_c || !pend_nz_c) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_q + WDW'(1);
        end
    end

    assign timeout_c = pend_nz_c & ~s.ack & (wd_q == WDW'(TIMEOUT - 1));
`else
    assign timeout_c = 1'b0;
`endif

    // Grant FSM: tie goes to the master that was not served last.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (m0.cyc && m1.cyc) begin
                    state_d = last_q ? GNT0 : GNT1;
                end else if (m0.cyc) begin
                    state_d = GNT0;
                end else if (m1.cyc) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                if ((!m0.cyc && next_zero_c) || timeout_c) begin
                    state_d = IDLE;
                    last_d  = 1'b0;
                end
            end
            GNT1: begin
                if ((!m1.cyc && next_zero_c) || timeout_c) begin
                    state_d = IDLE;
                    last_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_wb4_arbiter.sv
// tb_wb4_arbiter: self-checking bench for wb4_arbiter (ARCHBITSZ=32, MAXPENDING=4, TIMEOUT=8).
// Inputs change 1ns after posedge; outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_wb4_arbiter;
    localparam int unsigned AW   = 32;
    localparam int unsigned MAXP = 4;
    localparam int unsigned TMO  = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    wb4_arbiter_if #(.ARCHBITSZ(AW)) m0_bus ();
    wb4_arbiter_if #(.ARCHBITSZ(AW)) m1_bus ();
    wb4_arbiter_if #(.ARCHBITSZ(AW)) s_bus ();

    wb4_arbiter #(
        .ARCHBITSZ  (AW),
        .MAXPENDING (MAXP),
        .TIMEOUT    (TMO)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .m0     (m0_bus),
        .m1     (m1_bus),
        .s      (s_bus)
    );

    int checks = 0;
    int errors = 0;
    logic [AW-1:0] exp_q[$];   // expected read data, in ack order
    logic [AW-1:0] sq[$];      // addresses accepted by the slave, awaiting ack

    function automatic logic [AW-1:0] resp_data(input logic [AW-1:0] a);
        return a ^ AW'(32'hCAFE_0000);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        m0_bus.cyc = 0; m0_bus.stb = 0; m0_bus.we = 0; m0_bus.addr = '0; m0_bus.wdata = '0; m0_bus.sel = '0;
        m1_bus.cyc = 0; m1_bus.stb = 0; m1_bus.we = 0; m1_bus.addr = '0; m1_bus.wdata = '0; m1_bus.sel = '0;
        s_bus.stall = 0; s_bus.ack = 0; s_bus.rdata = '0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
        exp_q.delete();
        sq.delete();
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 0;
        m0_bus.cyc = 1; m0_bus.stb = 1; m1_bus.cyc = 1; s_bus.ack = 1;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (s_bus.cyc !== 1'b0 || s_bus.stb !== 1'b0) begin
            errors++; $display("FAIL reset_slave: cyc=%b stb=%b expected 0 0", s_bus.cyc, s_bus.stb);
        end
        checks++;
        if (m0_bus.stall !== 1'b1 || m1_bus.stall !== 1'b1) begin
            errors++; $display("FAIL reset_stall: m0=%b m1=%b expected 1 1", m0_bus.stall, m1_bus.stall);
        end
        checks++;
        if (m0_bus.ack !== 1'b0 || m1_bus.ack !== 1'b0) begin
            errors++; $display("FAIL reset_ack: m0=%b m1=%b expected 0 0", m0_bus.ack, m1_bus.ack);
        end
        drive_idle();
        rst_n = 1;
        tick();
    endtask

    task automatic test_single_read();
        logic [AW-1:0] exp;
        do_reset();
        m0_bus.cyc = 1; m0_bus.stb = 1; m0_bus.we = 0; m0_bus.addr = AW'(32'h10); m0_bus.sel = 4'hF;
        @(negedge clk);
        checks++;
        if (m0_bus.stall !== 1'b1 || s_bus.stb !== 1'b0) begin
            errors++; $display("FAIL read_grant_wait: stall=%b s_stb=%b expected 1 0", m0_bus.stall, s_bus.stb);
        end
        tick();
        @(negedge clk);
        checks++;
        if (s_bus.stb !== 1'b1 || s_bus.addr !== AW'(32'h10) || m0_bus.stall !== 1'b0 || s_bus.cyc !== 1'b1) begin
            errors++; $display("FAIL read_req: s_stb=%b s_addr=%h stall=%b s_cyc=%b expected 1 00000010 0 1",
                               s_bus.stb, s_bus.addr, m0_bus.stall, s_bus.cyc);
        end
        if (s_bus.stb && !s_bus.stall) exp_q.push_back(AW'(32'hDEADBEEF));
        tick();
        m0_bus.stb = 0; s_bus.ack = 1; s_bus.rdata = AW'(32'hDEADBEEF);
        @(negedge clk);
        checks++;
        if (m0_bus.ack !== 1'b1 || m1_bus.ack !== 1'b0) begin
            errors++; $display("FAIL read_ack: m0_ack=%b m1_ack=%b expected 1 0", m0_bus.ack, m1_bus.ack);
        end
        if (m0_bus.ack === 1'b1 && exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            checks++;
            if (m0_bus.rdata !== exp) begin
                errors++; $display("FAIL read_data: got %h expected %h", m0_bus.rdata, exp);
            end
        end
        tick();
        s_bus.ack = 0; m0_bus.cyc = 0;
        @(negedge clk);
        checks++;
        if (s_bus.cyc !== 1'b0) begin
            errors++; $display("FAIL read_release: s_cyc=%b expected 0", s_bus.cyc);
        end
        tick();
    endtask

    task automatic test_round_robin();
        do_reset();
        m0_bus.cyc = 1; m1_bus.cyc = 1;
        @(negedge clk);
        checks++;
        if (m0_bus.stall !== 1'b1 || m1_bus.stall !== 1'b1) begin
            errors++; $display("FAIL rr_idle: m0=%b m1=%b expected 1 1", m0_bus.stall, m1_bus.stall);
        end
        tick();
        @(negedge clk);
        checks++;
        if (m0_bus.stall !== 1'b0 || m1_bus.stall !== 1'b1) begin
            errors++; $display("FAIL rr_first_tie: m0_stall=%b m1_stall=%b expected 0 1", m0_bus.stall, m1_bus.stall);
        end
        tick();
        m0_bus.cyc = 0;
        @(negedge clk);
        tick();
        @(negedge clk);
        checks++;
        if (m0_bus.stall !== 1'b1 || m1_bus.stall !== 1'b1) begin
            errors++; $display("FAIL rr_gap: m0=%b m1=%b expected 1 1", m0_bus.stall, m1_bus.stall);
        end
        tick();
        @(negedge clk);
        checks++;
        if (m0_bus.stall !== 1'b1 || m1_bus.stall !== 1'b0) begin
            errors++; $display("FAIL rr_gnt1: m0_stall=%b m1_stall=%b expected 1 0", m0_bus.stall, m1_bus.stall);
        end
        tick();
        m1_bus.stb = 1; m1_bus.we = 1; m1_bus.addr = AW'(32'h20); m1_bus.wdata = AW'(32'h1234); m1_bus.sel = 4'h3;
        s_bus.stall = 1;
        @(negedge clk);
        checks++;
        if (s_bus.stb !== 1'b1 || s_bus.we !== 1'b1 || s_bus.addr !== AW'(32'h20) || s_bus.wdata !== AW'(32'h1234) ||
            s_bus.sel !== 4'h3 || m1_bus.stall !== 1'b1) begin
            errors++; $display("FAIL rr_mux1: stb=%b we=%b addr=%h wdata=%h sel=%h stall=%b expected 1 1 00000020 00001234 3 1",
                               s_bus.stb, s_bus.we, s_bus.addr, s_bus.wdata, s_bus.sel, m1_bus.stall);
        end
        tick();
        m1_bus.stb = 0; m1_bus.cyc = 0; s_bus.stall = 0;
        @(negedge clk);
        tick();
        m0_bus.cyc = 1; m1_bus.cyc = 1;
        @(negedge clk);
        tick();
        @(negedge clk);
        checks++;
        if (m0_bus.stall !== 1'b0 || m1_bus.stall !== 1'b1) begin
            errors++; $display("FAIL rr_second_tie: m0_stall=%b m1_stall=%b expected 0 1", m0_bus.stall, m1_bus.stall);
        end
        tick();
        drive_idle();
        tick();
        tick();
    endtask

    task automatic test_max_pending();
        int sent;
        int acks;
        int mpend;
        logic ack_driven;
        logic exp_stall;
        logic [AW-1:0] a;
        logic [AW-1:0] exp;
        sent = 0; acks = 0; mpend = 0;
        do_reset();
        m0_bus.cyc = 1; m0_bus.we = 1; m0_bus.sel = 4'hF;
        for (int c = 0; c < 60 && acks < 6; c++) begin
            m0_bus.stb   = (sent < 6);
            m0_bus.addr  = AW'(32'h100 + sent * 4);
            m0_bus.wdata = ~m0_bus.addr;
            if (c >= 8 && (c % 2) == 0 && sq.size() > 0) begin
                a = sq.pop_front();
                s_bus.ack = 1; s_bus.rdata = resp_data(a); ack_driven = 1;
            end else begin
                s_bus.ack = 0; s_bus.rdata = '0; ack_driven = 0;
            end
            @(negedge clk);
            exp_stall = (c == 0) || (mpend == int'(MAXP));
            checks++;
            if (m0_bus.stall !== exp_stall) begin
                errors++; $display("FAIL burst_stall: cycle %0d got %b expected %b", c, m0_bus.stall, exp_stall);
            end
            if (c == 8) begin
                checks++;
                if (sent != int'(MAXP)) begin
                    errors++; $display("FAIL burst_cap: accepted %0d before first ack, expected %0d", sent, MAXP);
                end
            end
            checks++;
            if (m0_bus.ack !== ack_driven) begin
                errors++; $display("FAIL burst_ack: cycle %0d got %b expected %b", c, m0_bus.ack, ack_driven);
            end
            if (m0_bus.ack === 1'b1 && exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                checks++;
                if (m0_bus.rdata !== exp) begin
                    errors++; $display("FAIL burst_data: got %h expected %h", m0_bus.rdata, exp);
                end
            end
            if (m0_bus.stb && !m0_bus.stall) begin
                sq.push_back(m0_bus.addr);
                exp_q.push_back(resp_data(m0_bus.addr));
                sent++; mpend++;
            end
            if (ack_driven) begin
                mpend--; acks++;
            end
            tick();
        end
        checks++;
        if (sent != 6 || acks != 6 || exp_q.size() != 0) begin
            errors++; $display("FAIL burst_count: accepted %0d acks %0d leftover %0d expected 6 6 0", sent, acks, exp_q.size());
        end
        m0_bus.stb = 0; m0_bus.cyc = 0; s_bus.ack = 0;
        @(negedge clk);
        checks++;
        if (s_bus.cyc !== 1'b0) begin
            errors++; $display("FAIL burst_release: s_cyc=%b expected 0", s_bus.cyc);
        end
        tick();
    endtask

    task automatic test_absorb();
        do_reset();
        m0_bus.cyc = 1; m0_bus.stb = 1; m0_bus.addr = AW'(32'h200); m0_bus.sel = 4'hF;
        @(negedge clk);
        tick();
        for (int c = 0; c < 2; c++) begin
            m0_bus.addr = AW'(32'h200 + c * 4);
            @(negedge clk);
            checks++;
            if (!(m0_bus.stb === 1'b1 && m0_bus.stall === 1'b0)) begin
                errors++; $display("FAIL absorb_issue: req %0d stall=%b expected 0", c, m0_bus.stall);
            end
            tick();
        end
        m0_bus.cyc = 0; m0_bus.stb = 0; m1_bus.cyc = 1;
        @(negedge clk);
        checks++;
        if (s_bus.cyc !== 1'b1 || s_bus.stb !== 1'b0 || m1_bus.stall !== 1'b1) begin
            errors++; $display("FAIL absorb_hold: s_cyc=%b s_stb=%b m1_stall=%b expected 1 0 1", s_bus.cyc, s_bus.stb, m1_bus.stall);
        end
        tick();
        for (int c = 0; c < 2; c++) begin
            s_bus.ack = 1; s_bus.rdata = AW'(32'h5555_0000 + c);
            @(negedge clk);
            checks++;
            if (m0_bus.ack !== 1'b0 || m1_bus.ack !== 1'b0 || m1_bus.stall !== 1'b1) begin
                errors++; $display("FAIL absorb_ack: ack %0d m0_ack=%b m1_ack=%b m1_stall=%b expected 0 0 1",
                                   c, m0_bus.ack, m1_bus.ack, m1_bus.stall);
            end
            tick();
        end
        s_bus.ack = 0;
        @(negedge clk);
        checks++;
        if (m1_bus.stall !== 1'b1 || s_bus.cyc !== 1'b0) begin
            errors++; $display("FAIL absorb_idle: m1_stall=%b s_cyc=%b expected 1 0", m1_bus.stall, s_bus.cyc);
        end
        tick();
        @(negedge clk);
        checks++;
        if (m1_bus.stall !== 1'b0) begin
            errors++; $display("FAIL absorb_grant1: m1_stall=%b expected 0", m1_bus.stall);
        end
        tick();
        drive_idle();
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        m0_bus.cyc = 1; m0_bus.stb = 1; m0_bus.sel = 4'hF;
        @(negedge clk);
        tick();
        for (int c = 0; c < 3; c++) begin
            m0_bus.addr = AW'(32'h400 + c * 4);
            @(negedge clk);
            checks++;
            if (m0_bus.stall !== 1'b0) begin
                errors++; $display("FAIL rstmid_issue: req %0d stall=%b expected 0", c, m0_bus.stall);
            end
            tick();
        end
        m0_bus.stb = 0; rst_n = 0;
        tick();
        rst_n = 1; m0_bus.cyc = 0;
        s_bus.ack = 1; s_bus.rdata = AW'(32'h0BAD_0BAD);
        @(negedge clk);
        checks++;
        if (s_bus.cyc !== 1'b0 || m0_bus.stall !== 1'b1 || m1_bus.stall !== 1'b1 || m0_bus.ack !== 1'b0 || m1_bus.ack !== 1'b0) begin
            errors++; $display("FAIL rstmid_idle: s_cyc=%b stalls=%b%b acks=%b%b expected 0 11 00",
                               s_bus.cyc, m0_bus.stall, m1_bus.stall, m0_bus.ack, m1_bus.ack);
        end
        tick();
        m0_bus.cyc = 1;
        @(negedge clk);
        checks++;
        if (m0_bus.ack !== 1'b0) begin
            errors++; $display("FAIL rstmid_stray: m0_ack=%b expected 0", m0_bus.ack);
        end
        tick();
        s_bus.ack = 0;
        @(negedge clk);
        checks++;
        if (m0_bus.stall !== 1'b0) begin
            errors++; $display("FAIL rstmid_regrant: m0_stall=%b expected 0", m0_bus.stall);
        end
        tick();
        m0_bus.cyc = 0;
        @(negedge clk);
        checks++;
        if (s_bus.cyc !== 1'b0) begin
            errors++; $display("FAIL rstmid_underflow: s_cyc=%b expected 0", s_bus.cyc);
        end
        tick();
        tick();
    endtask

    task automatic test_timeout();
        int seen;
        logic [AW-1:0] exp;
        do_reset();
        m0_bus.cyc = 1; m0_bus.stb = 1; m0_bus.addr = AW'(32'h300); m0_bus.sel = 4'hF;
        @(negedge clk);
        tick();
        @(negedge clk);
        checks++;
        if (m0_bus.stall !== 1'b0) begin
            errors++; $display("FAIL tmo_issue: stall=%b expected 0", m0_bus.stall);
        end
`ifdef WB4_ARBITER_TIMEOUT_EN
        exp_q.push_back('0);
`else
        exp_q.push_back(resp_data(AW'(32'h300)));
`endif
        tick();
        m0_bus.stb = 0; s_bus.rdata = AW'(32'h7777_7777);
`ifdef WB4_ARBITER_TIMEOUT_EN
        seen = -1;
        for (int k = 1; k <= 20 && seen < 0; k++) begin
            @(negedge clk);
            if (m0_bus.ack === 1'b1) begin
                seen = k;
                exp = exp_q.pop_front();
                checks++;
                if (m0_bus.rdata !== exp) begin
                    errors++; $display("FAIL tmo_data: got %h expected %h", m0_bus.rdata, exp);
                end
            end
            tick();
        end
        checks++;
        if (seen != int'(TMO)) begin
            errors++; $display("FAIL tmo_cycle: ack on cycle %0d expected %0d", seen, TMO);
        end
        @(negedge clk);
        checks++;
        if (m0_bus.stall !== 1'b1 || s_bus.cyc !== 1'b0) begin
            errors++; $display("FAIL tmo_idle: stall=%b s_cyc=%b expected 1 0", m0_bus.stall, s_bus.cyc);
        end
        tick();
`else
        seen = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (m0_bus.ack === 1'b1) seen++;
            tick();
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL tmo_none: %0d acks seen expected 0", seen);
        end
        @(negedge clk);
        checks++;
        if (s_bus.cyc !== 1'b1 || m0_bus.stall !== 1'b0) begin
            errors++; $display("FAIL tmo_wait: s_cyc=%b stall=%b expected 1 0", s_bus.cyc, m0_bus.stall);
        end
        tick();
        s_bus.ack = 1; s_bus.rdata = resp_data(AW'(32'h300));
        @(negedge clk);
        exp = exp_q.pop_front();
        checks++;
        if (m0_bus.ack !== 1'b1 || m0_bus.rdata !== exp) begin
            errors++; $display("FAIL tmo_late_ack: ack=%b data=%h expected 1 %h", m0_bus.ack, m0_bus.rdata, exp);
        end
        tick();
`endif
        drive_idle();
        tick();
        tick();
    endtask

    initial begin
        rst_n = 0;
        drive_idle();
        test_reset();
        test_single_read();
        test_round_robin();
        test_max_pending();
        test_absorb();
        test_reset_mid();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_watchdog: simulation exceeded time limit");
        $fatal(1, "time limit");
    end

endmodule
